// File: rtl/csi2_pkg.sv
// Shared constants and types for the single-lane CSI-2 packet parser.
// Latency: n/a (declarations only).
// Backpressure: n/a; the lane has no stall path.
package csi2_pkg;

    localparam logic [7:0]  SYNC_BYTE    = 8'hB8;
    localparam logic [15:0] CRC_POLY_R   = 16'h8408;  // x^16+x^12+x^5+1, reflected
    localparam logic [15:0] CRC_SEED     = 16'hFFFF;
    localparam logic [5:0]  DT_SHORT_MAX = 6'h0F;     // data types 0x00..0x0F are short packets

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        HDR0,
        HDR1,
        HDR2,
        HDR3,
        PAY,
        CRC0,
        CRC1,
        TRAIL
    } state_t;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } csi2_hdr_t;

endpackage

// File: rtl/csi2_crc16.sv
// Byte-wide next-state function of the CSI-2 payload CRC-16 (LSB-first, reflected poly).
// Latency: purely combinational.
// Backpressure: none.
// Ports: crc_in = current CRC, data_in = payload byte, crc_out = CRC after that byte.
module csi2_crc16
    import csi2_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Bit 0 of the byte enters first, matching the serial order on the wire.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) begin
                c = (c >> 1) ^ CRC_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/csi2_lane_pkt_parser.sv
// Single-lane CSI-2 packet parser: sync search, 4-byte header, payload stream, CRC check, stats.
// Latency: every output is registered, 1 cycle after the byte that causes it.
// Backpressure: none; each accepted byte is consumed in the cycle it arrives.
// Ports: clk/rst (sync, active-high); hs_active/byte_valid/byte_data from the D-PHY RX path;
//        hdr_* header fields with hdr_valid pulse; pl_* payload stream; crc_valid/crc_ok;
//        err_sync/err_trunc pulses; pkt_count/crc_err_count saturating statistics.
module csi2_lane_pkt_parser
    import csi2_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_active,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             hdr_valid,
    output logic [1:0]       hdr_vc,
    output logic [5:0]       hdr_dt,
    output logic [15:0]      hdr_wc,
    output logic [7:0]       hdr_ecc,
    output logic             hdr_short,
    output logic             pl_valid,
    output logic [7:0]       pl_data,
    output logic             pl_last,
    output logic             crc_valid,
    output logic             crc_ok,
    output logic             err_sync,
    output logic             err_trunc,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] crc_err_count
);

    localparam int              SC_W      = $clog2(SYNC_TIMEOUT) + 1;
    localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [7:0]       di_q, di_d;
    logic [15:0]      wc_q, wc_d;
    logic [15:0]      rem_q, rem_d;
    logic [15:0]      crc_q, crc_d;
    logic [15:0]      crc_next;
    logic [7:0]       crc_lsb_q, crc_lsb_d;
    csi2_hdr_t        hdr_q, hdr_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic             hdr_short_q, hdr_short_d;
    logic             pl_valid_q, pl_valid_d;
    logic [7:0]       pl_data_q, pl_data_d;
    logic             pl_last_q, pl_last_d;
    logic             crc_valid_q, crc_valid_d;
    logic             crc_ok_q, crc_ok_d;
    logic             err_sync_q, err_sync_d;
    logic             err_trunc_q, err_trunc_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] crc_err_cnt_q, crc_err_cnt_d;
    logic             byte_acc;
    logic             crc_match;

    assign byte_acc  = byte_valid && hs_active;
    assign crc_match = ({byte_data, crc_lsb_q} == crc_q);

    csi2_crc16 u_crc (
        .crc_in  (crc_q),
        .data_in (byte_data),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        di_d          = di_q;
        wc_d          = wc_q;
        rem_d         = rem_q;
        crc_d         = crc_q;
        crc_lsb_d     = crc_lsb_q;
        hdr_d         = hdr_q;
        hdr_short_d   = hdr_short_q;
        pl_data_d     = pl_data_q;
        pkt_cnt_d     = pkt_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        hdr_valid_d   = 1'b0;
        pl_valid_d    = 1'b0;
        pl_last_d     = 1'b0;
        crc_valid_d   = 1'b0;
        crc_ok_d      = 1'b0;
        err_sync_d    = 1'b0;
        err_trunc_d   = 1'b0;

        case (state_q)
            // A byte arriving in the same cycle hs_active rises is not examined.
            IDLE: begin
                sync_cnt_d = '0;
                if (hs_active) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!hs_active) begin
                    state_d = IDLE;
                end else if (byte_acc) begin
                    if (byte_data == SYNC_BYTE) begin
                        state_d = HDR0;
                    end else if (sync_cnt_q == SYNC_LAST) begin
                        err_sync_d = 1'b1;
                        state_d    = TRAIL;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SC_W'(1);
                    end
                end
            end
            TRAIL: begin
                if (!hs_active) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // HDR0..CRC1: losing HS here means the packet was cut short.
                if (!hs_active) begin
                    err_trunc_d = 1'b1;
                    state_d     = IDLE;
                end else if (byte_acc) begin
                    case (state_q)
                        HDR0: begin
                            di_d    = byte_data;
                            state_d = HDR1;
                        end
                        HDR1: begin
                            wc_d[7:0] = byte_data;
                            state_d   = HDR2;
                        end
                        HDR2: begin
                            wc_d[15:8] = byte_data;
                            state_d    = HDR3;
                        end
                        HDR3: begin
                            hdr_d       = '{vc: di_q[7:6], dt: di_q[5:0], wc: wc_q, ecc: byte_data};
                            hdr_short_d = (di_q[5:0] <= DT_SHORT_MAX);
                            hdr_valid_d = 1'b1;
                            if (pkt_cnt_q != '1) begin
                                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                            end
                            rem_d = wc_q;
                            crc_d = CRC_SEED;
                            if (di_q[5:0] <= DT_SHORT_MAX) begin
                                state_d = TRAIL;
                            end else if (wc_q == 16'd0) begin
                                state_d = CRC0;
                            end else begin
                                state_d = PAY;
                            end
                        end
                        PAY: begin
                            pl_valid_d = 1'b1;
                            pl_data_d  = byte_data;
                            crc_d      = crc_next;
                            rem_d      = rem_q - 16'd1;
                            if (rem_q == 16'd1) begin
                                pl_last_d = 1'b1;
                                state_d   = CRC0;
                            end
                        end
                        CRC0: begin
                            crc_lsb_d = byte_data;
                            state_d   = CRC1;
                        end
                        CRC1: begin
                            crc_valid_d = 1'b1;
                            crc_ok_d    = crc_match;
                            if (!crc_match && (crc_err_cnt_q != '1)) begin
                                crc_err_cnt_d = crc_err_cnt_q + CNT_W'(1);
                            end
                            state_d = TRAIL;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sync_cnt_q    <= '0;
            di_q          <= '0;
            wc_q          <= '0;
            rem_q         <= '0;
            crc_q         <= '0;
            crc_lsb_q     <= '0;
            hdr_q         <= '0;
            hdr_short_q   <= 1'b0;
            hdr_valid_q   <= 1'b0;
            pl_valid_q    <= 1'b0;
            pl_data_q     <= '0;
            pl_last_q     <= 1'b0;
            crc_valid_q   <= 1'b0;
            crc_ok_q      <= 1'b0;
            err_sync_q    <= 1'b0;
            err_trunc_q   <= 1'b0;
            pkt_cnt_q     <= '0;
            crc_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            di_q          <= di_d;
            wc_q          <= wc_d;
            rem_q         <= rem_d;
            crc_q         <= crc_d;
            crc_lsb_q     <= crc_lsb_d;
            hdr_q         <= hdr_d;
            hdr_short_q   <= hdr_short_d;
            hdr_valid_q   <= hdr_valid_d;
            pl_valid_q    <= pl_valid_d;
            pl_data_q     <= pl_data_d;
            pl_last_q     <= pl_last_d;
            crc_valid_q   <= crc_valid_d;
            crc_ok_q      <= crc_ok_d;
            err_sync_q    <= err_sync_d;
            err_trunc_q   <= err_trunc_d;
            pkt_cnt_q     <= pkt_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
        end
    end

    assign hdr_valid     = hdr_valid_q;
    assign hdr_vc        = hdr_q.vc;
    assign hdr_dt        = hdr_q.dt;
    assign hdr_wc        = hdr_q.wc;
    assign hdr_ecc       = hdr_q.ecc;
    assign hdr_short     = hdr_short_q;
    assign pl_valid      = pl_valid_q;
    assign pl_data       = pl_data_q;
    assign pl_last       = pl_last_q;
    assign crc_valid     = crc_valid_q;
    assign crc_ok        = crc_ok_q;
    assign err_sync      = err_sync_q;
    assign err_trunc     = err_trunc_q;
    assign pkt_count     = pkt_cnt_q;
    assign crc_err_count = crc_err_cnt_q;

endmodule

// File: tb/tb_csi2_lane_pkt_parser.sv
// Bench for csi2_lane_pkt_parser: directed byte stream with an expectation queue per output.
// Latency: n/a.
// Backpressure: n/a.
module tb_csi2_lane_pkt_parser;

    localparam int CNT_W        = 4;
    localparam int SYNC_TIMEOUT = 16;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             hs_active  = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data  = 8'h00;
    logic             hdr_valid;
    logic [1:0]       hdr_vc;
    logic [5:0]       hdr_dt;
    logic [15:0]      hdr_wc;
    logic [7:0]       hdr_ecc;
    logic             hdr_short;
    logic             pl_valid;
    logic [7:0]       pl_data;
    logic             pl_last;
    logic             crc_valid;
    logic             crc_ok;
    logic             err_sync;
    logic             err_trunc;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] crc_err_count;

    always #5 clk = ~clk;

    csi2_lane_pkt_parser #(.SYNC_TIMEOUT(SYNC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .hs_active     (hs_active),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .hdr_valid     (hdr_valid),
        .hdr_vc        (hdr_vc),
        .hdr_dt        (hdr_dt),
        .hdr_wc        (hdr_wc),
        .hdr_ecc       (hdr_ecc),
        .hdr_short     (hdr_short),
        .pl_valid      (pl_valid),
        .pl_data       (pl_data),
        .pl_last       (pl_last),
        .crc_valid     (crc_valid),
        .crc_ok        (crc_ok),
        .err_sync      (err_sync),
        .err_trunc     (err_trunc),
        .pkt_count     (pkt_count),
        .crc_err_count (crc_err_count)
    );

    typedef struct packed {
        logic [32:0]      f;    // {vc, dt, wc, ecc, short}
        logic [CNT_W-1:0] cnt;  // pkt_count expected alongside hdr_valid
    } hdr_exp_t;

    hdr_exp_t         hdr_exp[$];
    logic [8:0]       pl_exp[$];    // {last, data}
    logic [CNT_W:0]   crc_exp[$];   // {ok, crc_err_count}
    int               tests    = 0;
    int               fails    = 0;
    int               n_sync   = 0;
    int               n_trunc  = 0;
    int               spurious = 0;
    logic [CNT_W-1:0] exp_pkt     = '0;
    logic [CNT_W-1:0] exp_crc_err = '0;
    logic [15:0]      m_crc       = 16'hFFFF;
    hdr_exp_t         m_h;
    logic [8:0]       m_p;
    logic [CNT_W:0]   m_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [63:0] all_out();
        return 64'({hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_ecc, hdr_short, pl_valid, pl_data,
                    pl_last, crc_valid, crc_ok, err_sync, err_trunc, pkt_count, crc_err_count});
    endfunction

    // Output monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (hdr_valid === 1'b1) begin
            if (hdr_exp.size() == 0) spurious++;
            else begin
                m_h = hdr_exp.pop_front();
                chk("hdr_fields", 64'({hdr_vc, hdr_dt, hdr_wc, hdr_ecc, hdr_short}), 64'(m_h.f));
                chk("hdr_pkt_count", 64'(pkt_count), 64'(m_h.cnt));
            end
        end
        if (pl_valid === 1'b1) begin
            if (pl_exp.size() == 0) spurious++;
            else begin
                m_p = pl_exp.pop_front();
                chk("payload", 64'({pl_last, pl_data}), 64'(m_p));
            end
        end
        if (crc_valid === 1'b1) begin
            if (crc_exp.size() == 0) spurious++;
            else begin
                m_c = crc_exp.pop_front();
                chk("crc_result", 64'({crc_ok, crc_err_count}), 64'(m_c));
            end
        end
        if (err_sync === 1'b1)  n_sync++;
        if (err_trunc === 1'b1) n_trunc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        tick();
        byte_valid = 1'b1;
        byte_data  = b;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            tick();
            byte_valid = 1'b0;
        end
    endtask

    task automatic hs_set(input logic v);
        tick();
        hs_active  = v;
        byte_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        hdr_exp_t e;
        if (exp_pkt != '1) exp_pkt++;
        e.f   = {di, wc, ecc, (di[5:0] < 6'h10)};
        e.cnt = exp_pkt;
        hdr_exp.push_back(e);
        m_crc = 16'hFFFF;
        put(8'hB8);
        put(di);
        put(wc[7:0]);
        put(wc[15:8]);
        put(ecc);
    endtask

    task automatic send_pl(input logic [7:0] b, input logic last);
        pl_exp.push_back({last, b});
        m_crc = crc_step(m_crc, b);
        put(b);
    endtask

    task automatic send_crc(input logic [15:0] c);
        logic ok;
        ok = (c == m_crc);
        if (!ok && exp_crc_err != '1) exp_crc_err++;
        crc_exp.push_back({ok, exp_crc_err});
        put(c[7:0]);
        put(c[15:8]);
    endtask

    task automatic end_burst();
        gap(3);
        hs_set(1'b0);
        gap(2);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_hdr_left"}, 64'(hdr_exp.size()), 64'd0);
        chk({tag, "_pl_left"}, 64'(pl_exp.size()), 64'd0);
        chk({tag, "_crc_left"}, 64'(crc_exp.size()), 64'd0);
        chk({tag, "_spurious"}, 64'(spurious), 64'd0);
    endtask

    initial begin
        logic [15:0] c;

        // Bench CRC model against the standard check value for "123456789".
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = crc_step(c, 8'(8'h31 + i));
        chk("crc_model_check", 64'(c), 64'h6F91);

        // Reset state
        gap(3);
        tick();
        rst = 1'b0;
        chk("reset_outputs", all_out(), 64'd0);

        // 1: short packet after a junk byte
        hs_set(1'b1);
        put(8'h00);
        send_hdr(8'h00, 16'h1234, 8'hAA);
        end_burst();
        drain("t1");
        chk("t1_pkt_count", 64'(pkt_count), 64'd1);

        // 2: long packet, 4 payload bytes, correct CRC
        hs_set(1'b1);
        send_hdr(8'h6A, 16'd4, 8'h5C);
        send_pl(8'hDE, 1'b0);
        send_pl(8'hAD, 1'b0);
        send_pl(8'hBE, 1'b0);
        send_pl(8'hEF, 1'b1);
        send_crc(m_crc);
        end_burst();
        drain("t2");

        // 3: WC=0 long packets, good then bad CRC
        hs_set(1'b1);
        send_hdr(8'h2A, 16'd0, 8'h77);
        send_crc(16'hFFFF);
        end_burst();
        hs_set(1'b1);
        send_hdr(8'h2A, 16'd0, 8'h77);
        send_crc(16'hFEFF);
        end_burst();
        drain("t3");
        chk("t3_crc_err_count", 64'(crc_err_count), 64'(exp_crc_err));

        // 4: sync timeout on the 16th byte, then the rest of the burst is ignored
        hs_set(1'b1);
        repeat (15) put(8'h00);
        gap(2);
        chk("t4_no_err_sync_at_15", 64'(n_sync), 64'd0);
        put(8'h00);
        gap(2);
        chk("t4_err_sync_at_16", 64'(n_sync), 64'd1);
        put(8'hB8); put(8'h6A); put(8'h04); put(8'h00); put(8'h5C); put(8'hDE); put(8'hAD);
        gap(3);
        drain("t4_ignored");
        hs_set(1'b0);
        hs_set(1'b1);
        send_hdr(8'h01, 16'h0005, 8'h11);
        end_burst();
        drain("t4");
        chk("t4_err_sync_once", 64'(n_sync), 64'd1);

        // 5: EoT after 2 of 4 payload bytes, then a header truncation, then a clean burst
        hs_set(1'b1);
        send_hdr(8'h6A, 16'd4, 8'h5C);
        send_pl(8'hDE, 1'b0);
        send_pl(8'hAD, 1'b0);
        hs_set(1'b0);
        gap(3);
        chk("t5_err_trunc_pay", 64'(n_trunc), 64'd1);
        drain("t5_trunc");
        hs_set(1'b1);
        put(8'hB8);
        put(8'h12);
        hs_set(1'b0);
        gap(3);
        chk("t5_err_trunc_hdr", 64'(n_trunc), 64'd2);
        hs_set(1'b1);
        send_hdr(8'h2B, 16'd1, 8'h33);
        send_pl(8'h55, 1'b1);
        send_crc(m_crc);
        end_burst();
        drain("t5");
        chk("t5_err_trunc_total", 64'(n_trunc), 64'd2);

        // 6: counter saturation
        for (int i = 0; i < 12; i++) begin
            hs_set(1'b1);
            send_hdr(8'(i), 16'(i), 8'h42);
            end_burst();
        end
        chk("t6_pkt_sat", 64'(pkt_count), 64'hF);
        for (int i = 0; i < 16; i++) begin
            hs_set(1'b1);
            send_hdr(8'h2A, 16'd0, 8'h00);
            send_crc(16'h0000);
            end_burst();
        end
        chk("t6_crc_err_sat", 64'(crc_err_count), 64'hF);
        drain("t6");

        // 7: reset in the middle of the payload
        hs_set(1'b1);
        send_hdr(8'h6A, 16'd4, 8'h5C);
        send_pl(8'hDE, 1'b0);
        tick();
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hAD;
        tick();
        chk("t7_reset_outputs", all_out(), 64'd0);
        rst         = 1'b0;
        byte_valid  = 1'b0;
        exp_pkt     = '0;
        exp_crc_err = '0;
        gap(3);
        hs_set(1'b0);
        hs_set(1'b1);
        send_hdr(8'h02, 16'hBEEF, 8'h99);
        end_burst();
        drain("t7");
        chk("t7_pkt_count", 64'(pkt_count), 64'd1);
        chk("final_err_sync", 64'(n_sync), 64'd1);
        chk("final_err_trunc", 64'(n_trunc), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
